// File: rtl/wb2ahb_master.sv
// Wishbone-classic slave to AHB-Lite master bridge.
// Each Wishbone cycle becomes one AHB SINGLE transfer (NONSEQ, then IDLE).
// The AHB completion is returned as a one-cycle wb_ack_o or wb_err_o.
module wb2ahb_master #(
    parameter int          AW        = 32,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [AW-3:0]     wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [AW-1:0]     HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t     state;
    logic       aborted;
    logic       sel_ok;
    logic [2:0] sel_size;
    logic [1:0] sel_off;
    logic       deliver;

    assign HBURST = 3'b000;
    assign HPROT  = HPROT_VAL;

    // A response is only handed back if the initiator is still waiting for it
    // and has not dropped cyc at any point during the AHB transfer.
    assign deliver = wb_cyc_i & wb_stb_i & ~aborted;

    // Map byte selects onto an AHB size and the low address bits; any
    // non-contiguous or misaligned lane pattern is rejected.
    always_comb begin
        sel_ok   = 1'b1;
        sel_size = 3'd0;
        sel_off  = 2'b00;
        case (wb_sel_i)
            4'b1111: begin sel_size = 3'd2; sel_off = 2'b00; end
            4'b0011: begin sel_size = 3'd1; sel_off = 2'b00; end
            4'b1100: begin sel_size = 3'd1; sel_off = 2'b10; end
            4'b0001: begin sel_size = 3'd0; sel_off = 2'b00; end
            4'b0010: begin sel_size = 3'd0; sel_off = 2'b01; end
            4'b0100: begin sel_size = 3'd0; sel_off = 2'b10; end
            4'b1000: begin sel_size = 3'd0; sel_off = 2'b11; end
            default: sel_ok = 1'b0;
        endcase
    end

    // Bridge FSM; every bus output is registered here.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= S_IDLE;
            aborted  <= 1'b0;
            HTRANS   <= TRANS_IDLE;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HSIZE    <= 3'd0;
            HWDATA   <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
                        if (sel_ok) begin
                            HADDR   <= {wb_adr_i, sel_off};
                            HWRITE  <= wb_we_i;
                            HSIZE   <= sel_size;
                            HWDATA  <= wb_dat_i;
                            HTRANS  <= TRANS_NONSEQ;
                            aborted <= 1'b0;
                            state   <= S_ADDR;
                        end else begin
                            // No AHB transfer for an illegal lane pattern.
                            wb_err_o <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_ADDR: begin
                    // AHB cannot abort, so a dropped cyc only suppresses the reply.
                    if (!wb_cyc_i) aborted <= 1'b1;
                    if (HREADY) begin
                        HTRANS <= TRANS_IDLE;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!wb_cyc_i) aborted <= 1'b1;
                    // A two-cycle ERROR is recognised on its HREADY=1 cycle.
                    if (HREADY) begin
                        state <= S_DONE;
                        if (HRESP == 2'b00) begin
                            if (deliver) begin
                                wb_ack_o <= 1'b1;
                                if (!HWRITE) wb_dat_o <= HRDATA;
                            end
                        end else begin
                            if (deliver) wb_err_o <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    aborted  <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb2ahb_master.sv
// Directed bench for wb2ahb_master: cycle-by-cycle checks of both buses.
module tb_wb2ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [29:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    int vectors = 0;
    int miscompares = 0;

    wb2ahb_master #(.AW(32), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Advance one clock; outputs are then observed 1 ns after the edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_req(input logic [31:0] byte_adr, input logic [3:0] sel,
                          input logic we, input logic [31:0] dat);
        wb_adr_i = byte_adr[31:2];
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_dat_i = dat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    task automatic wb_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 2'b00;
        tick(); tick();

        // Reset state
        chk("rst_htrans", 32'(HTRANS), 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", 32'(HWRITE), 0);
        chk("rst_hsize", 32'(HSIZE), 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_dat_o", wb_dat_o, 0);
        chk("rst_ack", 32'(wb_ack_o), 0);
        chk("rst_err", 32'(wb_err_o), 0);
        chk("hburst", 32'(HBURST), 0);
        chk("hprot", 32'(HPROT), 32'h3);
        HRESET = 1'b0;
        tick();

        // Word write, zero-wait slave
        wb_req(32'h1000, 4'b1111, 1'b1, 32'hDEADBEEF);
        tick(); // cycle 1
        chk("wr_c1_htrans", 32'(HTRANS), 2);
        chk("wr_c1_haddr", HADDR, 32'h1000);
        chk("wr_c1_hsize", 32'(HSIZE), 2);
        chk("wr_c1_hwrite", 32'(HWRITE), 1);
        chk("wr_c1_ack", 32'(wb_ack_o), 0);
        tick(); // cycle 2
        chk("wr_c2_htrans", 32'(HTRANS), 0);
        chk("wr_c2_hwdata", HWDATA, 32'hDEADBEEF);
        chk("wr_c2_ack", 32'(wb_ack_o), 0);
        tick(); // cycle 3
        chk("wr_c3_ack", 32'(wb_ack_o), 1);
        chk("wr_c3_err", 32'(wb_err_o), 0);
        // Back-to-back: stb stays high with a new byte write
        wb_req(32'h0010, 4'b1000, 1'b1, 32'h5A000000);
        tick(); // cycle 4
        chk("b2b_c4_ack", 32'(wb_ack_o), 0);
        chk("b2b_c4_htrans", 32'(HTRANS), 0);
        tick(); // cycle 5
        chk("b2b_c5_htrans", 32'(HTRANS), 2);
        chk("b2b_c5_haddr", HADDR, 32'h0013);
        chk("b2b_c5_hsize", 32'(HSIZE), 0);
        tick(); // cycle 6
        chk("b2b_c6_hwdata", HWDATA, 32'h5A000000);
        tick(); // cycle 7
        chk("b2b_c7_ack", 32'(wb_ack_o), 1);
        wb_idle();
        tick();
        chk("b2b_after_ack", 32'(wb_ack_o), 0);

        // Byte read with two data-phase wait states
        wb_req(32'h2000, 4'b0100, 1'b0, 32'h0);
        HRDATA = 32'h00AB0000;
        tick(); // cycle 1
        chk("rd_c1_htrans", 32'(HTRANS), 2);
        chk("rd_c1_haddr", HADDR, 32'h2002);
        chk("rd_c1_hsize", 32'(HSIZE), 0);
        chk("rd_c1_hwrite", 32'(HWRITE), 0);
        tick(); // cycle 2
        HREADY = 1'b0;
        tick(); // cycle 3
        chk("rd_c3_ack", 32'(wb_ack_o), 0);
        tick(); // cycle 4
        chk("rd_c4_ack", 32'(wb_ack_o), 0);
        HREADY = 1'b1;
        tick(); // cycle 5
        chk("rd_c5_ack", 32'(wb_ack_o), 1);
        chk("rd_c5_dat", wb_dat_o, 32'h00AB0000);
        wb_idle();
        HRDATA = 32'hFFFFFFFF;
        tick();
        chk("rd_hold_dat", wb_dat_o, 32'h00AB0000);

        // Illegal sel 0101
        wb_req(32'h2400, 4'b0101, 1'b1, 32'h11111111);
        tick(); // cycle 1
        chk("ill_c1_err", 32'(wb_err_o), 1);
        chk("ill_c1_ack", 32'(wb_ack_o), 0);
        chk("ill_c1_htrans", 32'(HTRANS), 0);
        wb_idle();
        tick();
        chk("ill_c2_err", 32'(wb_err_o), 0);
        chk("ill_c2_htrans", 32'(HTRANS), 0);

        // AHB two-cycle ERROR on a read
        wb_req(32'h3000, 4'b1111, 1'b0, 32'h0);
        HRDATA = 32'h12345678;
        tick(); // cycle 1
        chk("er_c1_htrans", 32'(HTRANS), 2);
        tick(); // cycle 2
        HREADY = 1'b0; HRESP = 2'b01;
        tick(); // cycle 3
        chk("er_c3_err", 32'(wb_err_o), 0);
        chk("er_c3_htrans", 32'(HTRANS), 0);
        HREADY = 1'b1;
        tick(); // cycle 4
        chk("er_c4_err", 32'(wb_err_o), 1);
        chk("er_c4_ack", 32'(wb_ack_o), 0);
        chk("er_c4_dat", wb_dat_o, 32'h00AB0000);
        wb_idle();
        HRESP = 2'b00;
        tick();
        chk("er_c5_err", 32'(wb_err_o), 0);

        // Abort: cyc dropped during an extended address phase
        wb_req(32'h4000, 4'b0011, 1'b1, 32'h0000BEEF);
        tick(); // cycle 1
        chk("ab_c1_hsize", 32'(HSIZE), 1);
        wb_idle();
        HREADY = 1'b0;
        tick(); // cycle 2
        chk("ab_c2_htrans", 32'(HTRANS), 2);
        tick(); // cycle 3
        chk("ab_c3_htrans", 32'(HTRANS), 2);
        tick(); // cycle 4
        chk("ab_c4_htrans", 32'(HTRANS), 2);
        chk("ab_c4_haddr", HADDR, 32'h4000);
        HREADY = 1'b1;
        tick(); // cycle 5
        chk("ab_c5_htrans", 32'(HTRANS), 0);
        chk("ab_c5_hwdata", HWDATA, 32'h0000BEEF);
        tick(); // cycle 6
        chk("ab_c6_ack", 32'(wb_ack_o), 0);
        chk("ab_c6_err", 32'(wb_err_o), 0);
        tick(); // cycle 7
        chk("ab_c7_ack", 32'(wb_ack_o), 0);
        chk("ab_c7_htrans", 32'(HTRANS), 0);

        // Reset while in the data phase
        wb_req(32'h5000, 4'b1111, 1'b0, 32'h0);
        HRDATA = 32'hCAFEF00D;
        tick(); // cycle 1
        chk("rs_c1_htrans", 32'(HTRANS), 2);
        tick(); // cycle 2, data phase
        HRESET = 1'b1;
        wb_idle();
        tick();
        HRESET = 1'b0;
        chk("rs_htrans", 32'(HTRANS), 0);
        chk("rs_haddr", HADDR, 0);
        chk("rs_hwdata", HWDATA, 0);
        chk("rs_dat_o", wb_dat_o, 0);
        chk("rs_ack", 32'(wb_ack_o), 0);
        chk("rs_err", 32'(wb_err_o), 0);
        // Subsequent word read
        wb_req(32'h5000, 4'b1111, 1'b0, 32'h0);
        HRDATA = 32'h0BADCAFE;
        tick(); // cycle 1
        chk("rs2_c1_htrans", 32'(HTRANS), 2);
        chk("rs2_c1_haddr", HADDR, 32'h5000);
        tick(); // cycle 2
        chk("rs2_c2_ack", 32'(wb_ack_o), 0);
        tick(); // cycle 3
        chk("rs2_c3_ack", 32'(wb_ack_o), 1);
        chk("rs2_c3_dat", wb_dat_o, 32'h0BADCAFE);
        wb_idle();
        tick();
        chk("rs2_c4_ack", 32'(wb_ack_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
